// File: rtl/tb_dina_map_pkg.sv
// Shared encodings for the temp-bank write and read mappers: TB_dina_sel modes,
// the NEW-mode half-select values and the write-mapper FSM states.
package tb_dina_map_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10,
    DIR_NEW  = 2'b11
  } dir_e;

  // l_k_0 values in NEW mode: 1 fills the low half of the TB lanes, 0 the high half
  localparam logic DIR_NEW_0 = 1'b0;
  localparam logic DIR_NEW_1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/tb_dina_map_steer.sv
// Combinational lane steering from an RSA output row to TB write data/enables.
// X must equal L; NEW mode moves the low half of the RSA lanes into one TB half.
module tb_lane_steer
  import tb_dina_map_pkg::*;
#(
  parameter int X      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = 16
) (
  input  dir_e                    mode,
  input  logic                    l_k_0,
  input  logic [X*RSA_DW-1:0]     din,
  output logic [L*RSA_DW-1:0]     dina,
  output logic [L-1:0]            wea
);

  localparam int HALF = L / 2;

  always_comb begin
    dina = '0;
    wea  = '0;
    case (mode)
      DIR_POS: begin
        for (int i = 0; i < L; i++) begin
          dina[i*RSA_DW +: RSA_DW] = din[i*RSA_DW +: RSA_DW];
        end
        wea = '1;
      end
      DIR_NEG: begin
        for (int i = 0; i < L; i++) begin
          dina[i*RSA_DW +: RSA_DW] = din[(X-1-i)*RSA_DW +: RSA_DW];
        end
        wea = '1;
      end
      DIR_NEW: begin
        for (int i = 0; i < HALF; i++) begin
          case (l_k_0)
            DIR_NEW_1: begin
              dina[i*RSA_DW +: RSA_DW] = din[i*RSA_DW +: RSA_DW];
              wea[i] = 1'b1;
            end
            DIR_NEW_0: begin
              dina[(i+HALF)*RSA_DW +: RSA_DW] = din[i*RSA_DW +: RSA_DW];
              wea[i+HALF] = 1'b1;
            end
          endcase
        end
      end
      default: begin
        dina = '0;
        wea  = '0;
      end
    endcase
  end

endmodule

// File: rtl/tb_dina_map.sv
// Burst writer from the RSA output stream into the temp bank, one row per valid
// cycle, with every output registered (one cycle from C_TB_valid to TB write).
module tb_dina_map
  import tb_dina_map_pkg::*;
#(
  parameter int X      = 4,
  parameter int L      = 4,
  parameter int RSA_DW = 16,
  parameter int TB_AW  = 8,
  parameter int LEN_DW = 5
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [1:0]            TB_dina_sel,
  input  logic                  l_k_0,
  input  logic [TB_AW-1:0]      base_addr,
  input  logic [LEN_DW-1:0]     burst_len,
  input  logic                  C_TB_valid,
  input  logic [X*RSA_DW-1:0]   C_TB_dout,
  output logic                  TB_ena,
  output logic [L-1:0]          TB_wea,
  output logic [TB_AW-1:0]      TB_addra,
  output logic [L*RSA_DW-1:0]   TB_dina,
  output logic                  busy,
  output logic                  done
);

  state_e              state_q, state_d;
  dir_e                mode_q, mode_d;
  logic                lk_q, lk_d;
  logic [TB_AW-1:0]    base_q, base_d;
  logic [LEN_DW-1:0]   len_q, len_d;
  logic [LEN_DW-1:0]   cnt_q, cnt_d;
  logic                ena_q, ena_d;
  logic [L-1:0]        wea_q, wea_d;
  logic [TB_AW-1:0]    addra_q, addra_d;
  logic [L*RSA_DW-1:0] dina_q, dina_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [L*RSA_DW-1:0] steer_dina;
  logic [L-1:0]        steer_wea;
  logic                last_row;

  tb_lane_steer #(
    .X      (X),
    .L      (L),
    .RSA_DW (RSA_DW)
  ) u_steer (
    .mode  (mode_q),
    .l_k_0 (lk_q),
    .din   (C_TB_dout),
    .dina  (steer_dina),
    .wea   (steer_wea)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    lk_d     = lk_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ena_d    = 1'b0;
    wea_d    = '0;
    dina_d   = '0;
    addra_d  = addra_q;
    last_row = (cnt_q == len_q - LEN_DW'(1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = dir_e'(TB_dina_sel);
          lk_d    = l_k_0;
          base_d  = base_addr;
          len_d   = burst_len;
          cnt_d   = '0;
          state_d = (burst_len == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (C_TB_valid) begin
          // IDLE mode still consumes rows but never enables the bank
          ena_d   = (mode_q != DIR_IDLE);
          wea_d   = steer_wea;
          dina_d  = steer_dina;
          addra_d = base_q + TB_AW'(cnt_q);
          cnt_d   = cnt_q + LEN_DW'(1);
          if (last_row) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_WRITE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= DIR_IDLE;
      lk_q    <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      wea_q   <= '0;
      addra_q <= '0;
      dina_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lk_q    <= lk_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TB_ena   = ena_q;
  assign TB_wea   = wea_q;
  assign TB_addra = addra_q;
  assign TB_dina  = dina_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tb_dina_map.sv
// Bench for tb_dina_map: steering table, directed burst sequences, then random
// traffic, all checked every cycle against a burst-level reference model.
module tb_tb_dina_map;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [1:0]  sel;
  logic        lk;
  logic [7:0]  base;
  logic [4:0]  len;
  logic        valid;
  logic [63:0] dout;

  logic        TB_ena;
  logic [3:0]  TB_wea;
  logic [7:0]  TB_addra;
  logic [63:0] TB_dina;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  tb_dina_map #(
    .X(4), .L(4), .RSA_DW(16), .TB_AW(8), .LEN_DW(5)
  ) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .TB_dina_sel (sel),
    .l_k_0       (lk),
    .base_addr   (base),
    .burst_len   (len),
    .C_TB_valid  (valid),
    .C_TB_dout   (dout),
    .TB_ena      (TB_ena),
    .TB_wea      (TB_wea),
    .TB_addra    (TB_addra),
    .TB_dina     (TB_dina),
    .busy        (busy),
    .done        (done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: burst phase 0 = waiting for start, 1 = taking rows, 2 = done pulse
  int         m_phase = 0;
  int         m_mode, m_base, m_len, m_rows;
  logic       m_lk;
  logic       e_ena, e_busy, e_done, e_addr_chk;
  logic [3:0] e_wea;
  logic [7:0] e_addr;
  logic [63:0] e_dina;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] row4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic model_tick();
    logic [15:0] li[4];
    logic [15:0] lo[4];
    e_ena = 0; e_wea = 0; e_dina = 0; e_addr_chk = 0;
    if (sys_rst) begin
      m_phase = 0; m_mode = 0; m_lk = 0; m_base = 0; m_len = 0; m_rows = 0;
      e_addr = 0; e_addr_chk = 1; e_busy = 0; e_done = 0;
      return;
    end
    case (m_phase)
      0: if (start) begin
        m_mode = int'(sel); m_lk = lk; m_base = int'(base); m_len = int'(len); m_rows = 0;
        m_phase = (len == 0) ? 2 : 1;
      end
      1: if (valid) begin
        for (int i = 0; i < 4; i++) begin
          li[i] = dout[16*i +: 16];
          lo[i] = 16'h0;
        end
        case (m_mode)
          1: begin lo = li; e_wea = 4'b1111; end
          2: begin for (int i = 0; i < 4; i++) lo[i] = li[3-i]; e_wea = 4'b1111; end
          3: if (m_lk) begin lo[0] = li[0]; lo[1] = li[1]; e_wea = 4'b0011; end
             else begin lo[2] = li[0]; lo[3] = li[1]; e_wea = 4'b1100; end
          default: e_wea = 4'b0000;
        endcase
        e_ena      = (m_mode != 0);
        e_addr     = 8'((m_base + m_rows) % 256);
        e_addr_chk = e_ena;
        e_dina     = {lo[3], lo[2], lo[1], lo[0]};
        m_rows++;
        if (m_rows == m_len) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    e_busy = (m_phase == 1);
    e_done = (m_phase == 2);
  endtask

  // advance one clock with the current inputs, then compare against the model
  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
    chk("ena",  {63'd0, TB_ena}, {63'd0, e_ena});
    chk("wea",  {60'd0, TB_wea}, {60'd0, e_wea});
    chk("dina", TB_dina, e_dina);
    chk("busy", {63'd0, busy}, {63'd0, e_busy});
    chk("done", {63'd0, done}, {63'd0, e_done});
    if (e_addr_chk) chk("addra", {56'd0, TB_addra}, {56'd0, e_addr});
  endtask

  task automatic begin_burst(input logic [1:0] s, input logic k, input logic [7:0] b, input logic [4:0] n);
    sel = s; lk = k; base = b; len = n; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic        lk;
    logic [63:0] din;
    logic [63:0] x_dina;
    logic [3:0]  x_wea;
    logic        x_ena;
  } vec_t;

  vec_t tbl[6];

  initial begin
    sys_rst = 1; start = 0; sel = 0; lk = 0; base = 0; len = 0; valid = 0; dout = 0;
    cycle();
    cycle();
    chk("rst_ena",   {63'd0, TB_ena}, 64'd0);
    chk("rst_addra", {56'd0, TB_addra}, 64'd0);
    sys_rst = 0;
    cycle();

    tbl[0] = '{2'b01, 1'b0, row4(16'h1, 16'h2, 16'h3, 16'h4), row4(16'h1, 16'h2, 16'h3, 16'h4), 4'b1111, 1'b1};
    tbl[1] = '{2'b10, 1'b0, row4(16'h1, 16'h2, 16'h3, 16'h4), row4(16'h4, 16'h3, 16'h2, 16'h1), 4'b1111, 1'b1};
    tbl[2] = '{2'b11, 1'b0, row4(16'hAAAA, 16'hBBBB, 16'h1111, 16'h2222), row4(16'h0, 16'h0, 16'hAAAA, 16'hBBBB), 4'b1100, 1'b1};
    tbl[3] = '{2'b11, 1'b1, row4(16'hAAAA, 16'hBBBB, 16'h1111, 16'h2222), row4(16'hAAAA, 16'hBBBB, 16'h0, 16'h0), 4'b0011, 1'b1};
    tbl[4] = '{2'b00, 1'b0, row4(16'h5, 16'h6, 16'h7, 16'h8), 64'd0, 4'b0000, 1'b0};
    tbl[5] = '{2'b10, 1'b1, row4(16'h8000, 16'hFFFF, 16'h0001, 16'h7FFF), row4(16'h7FFF, 16'h0001, 16'hFFFF, 16'h8000), 4'b1111, 1'b1};

    for (int i = 0; i < 6; i++) begin
      begin_burst(tbl[i].sel, tbl[i].lk, 8'(8'h40 + i), 5'd1);
      valid = 1; dout = tbl[i].din;
      cycle();
      chk("tbl_ena",  {63'd0, TB_ena}, {63'd0, tbl[i].x_ena});
      chk("tbl_wea",  {60'd0, TB_wea}, {60'd0, tbl[i].x_wea});
      chk("tbl_dina", TB_dina, tbl[i].x_dina);
      chk("tbl_done", {63'd0, done}, 64'd1);
      if (tbl[i].x_ena) chk("tbl_addra", {56'd0, TB_addra}, {56'd0, 8'(8'h40 + i)});
      valid = 0;
      cycle();
    end

    // POS burst of three rows from 0x10
    begin_burst(2'b01, 1'b0, 8'h10, 5'd3);
    for (int r = 0; r < 3; r++) begin
      valid = 1; dout = row4(16'(4*r+1), 16'(4*r+2), 16'(4*r+3), 16'(4*r+4));
      cycle();
      chk("pos_addra", {56'd0, TB_addra}, {56'd0, 8'(8'h10 + r)});
      chk("pos_dina",  TB_dina, row4(16'(4*r+1), 16'(4*r+2), 16'(4*r+3), 16'(4*r+4)));
      chk("pos_done",  {63'd0, done}, {63'd0, r == 2});
    end
    valid = 0;
    cycle();

    // stall between rows and address wrap at 0xFF
    begin_burst(2'b01, 1'b0, 8'hFF, 5'd2);
    valid = 1; dout = row4(16'h11, 16'h22, 16'h33, 16'h44);
    cycle();
    chk("wrap_addr0", {56'd0, TB_addra}, 64'hFF);
    valid = 0;
    for (int s = 0; s < 2; s++) begin
      cycle();
      chk("stall_ena", {63'd0, TB_ena}, 64'd0);
      chk("stall_busy", {63'd0, busy}, 64'd1);
    end
    valid = 1; dout = row4(16'h55, 16'h66, 16'h77, 16'h88);
    cycle();
    chk("wrap_addr1", {56'd0, TB_addra}, 64'h00);
    chk("wrap_done",  {63'd0, done}, 64'd1);
    // start during the done cycle must be ignored
    valid = 0; start = 1; sel = 2'b01; base = 8'h99; len = 5'd3;
    cycle();
    start = 0;
    chk("done_start_busy", {63'd0, busy}, 64'd0);
    cycle();

    // zero-length burst
    begin_burst(2'b01, 1'b0, 8'h05, 5'd0);
    chk("len0_done", {63'd0, done}, 64'd1);
    chk("len0_ena",  {63'd0, TB_ena}, 64'd0);
    cycle();
    chk("len0_done_drop", {63'd0, done}, 64'd0);

    // start while busy has no effect
    begin_burst(2'b10, 1'b0, 8'h20, 5'd2);
    valid = 1; dout = row4(16'h1, 16'h2, 16'h3, 16'h4);
    cycle();
    valid = 0; start = 1; base = 8'h80; len = 5'd5;
    cycle();
    start = 0; valid = 1; dout = row4(16'h5, 16'h6, 16'h7, 16'h8);
    cycle();
    chk("busy_start_addr", {56'd0, TB_addra}, 64'h21);
    chk("busy_start_done", {63'd0, done}, 64'd1);
    valid = 0;
    cycle();

    // reset mid-burst, with a row presented in the reset cycle
    begin_burst(2'b01, 1'b0, 8'h30, 5'd4);
    valid = 1; dout = row4(16'hA, 16'hB, 16'hC, 16'hD);
    cycle();
    cycle();
    sys_rst = 1;
    cycle();
    chk("mid_rst_ena",   {63'd0, TB_ena}, 64'd0);
    chk("mid_rst_dina",  TB_dina, 64'd0);
    chk("mid_rst_addra", {56'd0, TB_addra}, 64'd0);
    chk("mid_rst_busy",  {63'd0, busy}, 64'd0);
    sys_rst = 0;
    cycle();
    chk("post_rst_ena", {63'd0, TB_ena}, 64'd0);
    valid = 0;
    begin_burst(2'b01, 1'b0, 8'h50, 5'd1);
    valid = 1;
    cycle();
    chk("post_rst_addra", {56'd0, TB_addra}, 64'h50);
    valid = 0;
    cycle();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      sys_rst = ($urandom_range(0, 59) == 0);
      start   = ($urandom_range(0, 5) == 0);
      sel     = 2'($urandom_range(0, 3));
      lk      = 1'($urandom_range(0, 1));
      base    = 8'($urandom);
      len     = 5'($urandom_range(0, 6));
      valid   = ($urandom_range(0, 3) != 0);
      dout    = {$urandom, $urandom};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
